// File: rtl/fir_coef_loader.sv
// Coefficient loader for the tapped-delay FIR: stages DELAYS+1 words in a shadow bank and swaps them onto b atomically.
// Optional trailing checksum word enabled by defining FIR_COEF_CHECKSUM_EN.
module fir_coef_loader #(
  parameter int DELAYS = 3,
  parameter int N      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [N-1:0]            coef_in,
  input  logic                    coef_valid,
  output logic                    coef_ready,
  output logic [(DELAYS+1)*N-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int IDX_W = (DELAYS > 0) ? $clog2(DELAYS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DELAYS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef FIR_COEF_CHECKSUM_EN
    CHECK  = 2'd2,
`endif
    COMMIT = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] index_reg, index_next;
  logic [N-1:0]     shadow_word [0:DELAYS];
  logic             shadow_wr;
  logic             commit;
  logic             done_reg;

`ifdef FIR_COEF_CHECKSUM_EN
  logic [N-1:0] shadow_sum;
  logic         err_next;
  logic         err_reg;

  // Modulo-2^N sum of the staged bank; truncation comes from the accumulator width.
  always_comb begin
    shadow_sum = '0;
    for (int i = 0; i <= DELAYS; i++) begin
      shadow_sum = shadow_sum + shadow_word[i];
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    shadow_wr  = 1'b0;
    commit     = 1'b0;
    coef_ready = 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
    err_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = LOAD;
          index_next = '0;
        end
      end
      LOAD: begin
        coef_ready = 1'b1;
        // abort wins over a transfer presented on the same edge
        if (abort) begin
          state_next = IDLE;
        end else if (coef_valid) begin
          shadow_wr = 1'b1;
          if (index_reg == LAST_IDX) begin
`ifdef FIR_COEF_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = COMMIT;
`endif
          end else begin
            index_next = index_reg + IDX_W'(1);
          end
        end
      end
`ifdef FIR_COEF_CHECKSUM_EN
      CHECK: begin
        coef_ready = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (coef_valid) begin
          if (coef_in == shadow_sum) begin
            state_next = COMMIT;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      index_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      done_reg  <= commit;
    end
  end

`ifdef FIR_COEF_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  // One shadow slot and one live slot per coefficient; live slots only change on commit.
  genvar gi;
  generate
    for (gi = 0; gi <= DELAYS; gi++) begin : g_slot
      logic [N-1:0] shadow_q;
      logic [N-1:0] live_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_q <= '0;
        end else if (shadow_wr && (index_reg == IDX_W'(gi))) begin
          shadow_q <= coef_in;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          live_q <= '0;
        end else if (commit) begin
          live_q <= shadow_q;
        end
      end

      assign shadow_word[gi]  = shadow_q;
      assign b[gi*N +: N]     = live_q;
    end
  endgenerate

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomised self-checking bench for fir_coef_loader (DELAYS=3, N=32); reference keeps the expected
// coefficient set as a plain array and derives latencies from word and gap counts.
module tb_fir_coef_loader;

  localparam int DELAYS = 3;
  localparam int N      = 32;
  localparam int NC     = DELAYS + 1;
`ifdef FIR_COEF_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [N-1:0]    coef_in = '0;
  logic            coef_valid = 1'b0;
  logic            coef_ready;
  logic [NC*N-1:0] b;
  logic            busy;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [N-1:0] model_b [0:NC-1];
  logic [N-1:0] ld_words [0:7];
  int           ld_gaps [0:7];
  int           ld_n;

  fir_coef_loader #(.DELAYS(DELAYS), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .coef_in(coef_in),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .b(b), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*N-1:0] model_vec();
    logic [NC*N-1:0] v;
    for (int i = 0; i < NC; i++) v[i*N +: N] = model_b[i];
    return v;
  endfunction

  // Fill ld_words with the given coefficients plus, when enabled, a good or bad checksum word.
  task automatic set_words(input logic [N-1:0] w0, w1, w2, w3, input bit bad_sum);
    logic [N-1:0] s;
    ld_words[0] = w0; ld_words[1] = w1; ld_words[2] = w2; ld_words[3] = w3;
    s = w0 + w1 + w2 + w3;
    ld_words[4] = bad_sum ? s + 32'd1 : s;
    ld_n = CSUM ? NC + 1 : NC;
    for (int k = 0; k < 8; k++) ld_gaps[k] = 0;
  endtask

  task automatic do_load(input string tag, input bit expect_commit,
                         input bit start_in_load, input bit start_in_commit);
    int edges, gap_sum, d0, e0, lat_exp;
    bit saw_done, saw_err;
    d0 = done_cnt; e0 = err_cnt; gap_sum = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    checks++;
    if (busy !== 1'b1 || coef_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_enter_load: busy=%b coef_ready=%b required 1 1", tag, busy, coef_ready);
    end
    for (int k = 0; k < ld_n; k++) begin
      for (int g = 0; g < ld_gaps[k]; g++) begin
        coef_valid = 1'b0;
        coef_in = $urandom;
        tick();
        edges++;
        gap_sum++;
      end
      coef_valid = 1'b1;
      coef_in = ld_words[k];
      if (start_in_load && k == 1) start = 1'b1;
      tick();
      start = 1'b0;
      edges++;
    end
    coef_valid = 1'b0;
    saw_err = (err === 1'b1);
    saw_done = 1'b0;
    if (!saw_err) begin
      for (int t = 0; t < 8 && !saw_done; t++) begin
        if (start_in_commit && t == 0) start = 1'b1;
        tick();
        start = 1'b0;
        edges++;
        saw_done = (done === 1'b1);
      end
    end
    if (expect_commit) begin
      lat_exp = ld_n + 2 + gap_sum;
      checks++;
      if (!saw_done || edges != lat_exp) begin
        errors++;
        $display("FAIL %s_done_latency: saw_done=%b edges=%0d required done after %0d", tag, saw_done, edges, lat_exp);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_with_done: busy=%b required 0", tag, busy);
      end
      for (int i = 0; i < NC; i++) model_b[i] = ld_words[i];
    end else begin
      lat_exp = ld_n + 1 + gap_sum;
      checks++;
      if (!saw_err || edges != lat_exp) begin
        errors++;
        $display("FAIL %s_err_latency: saw_err=%b edges=%0d required err after %0d", tag, saw_err, edges, lat_exp);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: done=%b err=%b busy=%b required 0 0 0", tag, done, err, busy);
    end
    checks++;
    if ((done_cnt - d0) != int'(expect_commit) || (err_cnt - e0) != int'(!expect_commit)) begin
      errors++;
      $display("FAIL %s_pulse_count: done=%0d err=%0d required %0d %0d", tag, done_cnt - d0,
               err_cnt - e0, int'(expect_commit), int'(!expect_commit));
    end
    checks++;
    if (b !== model_vec()) begin
      errors++;
      $display("FAIL %s_b: b=%h required %h", tag, b, model_vec());
    end
    $display("load %s: commit=%b edges=%0d b=%h", tag, expect_commit, edges, b);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (b !== '0 || coef_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: b=%h ready=%b busy=%b done=%b err=%b required all 0", b, coef_ready, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || b !== '0) begin
      errors++;
      $display("FAIL reset_release: busy=%b b=%h required 0 0", busy, b);
    end
    for (int i = 0; i < NC; i++) model_b[i] = '0;
    $display("reset: b=%h busy=%b", b, busy);
  endtask

  task automatic test_basic();
    set_words(32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    do_load("basic", 1'b1, 1'b0, 1'b0);
    checks++;
    if (b !== 128'h00000004_00000003_00000002_00000001) begin
      errors++;
      $display("FAIL basic_const: b=%h required 00000004000000030000000200000001", b);
    end
  endtask

  task automatic test_stalls();
    set_words(32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    ld_gaps[1] = 2; ld_gaps[2] = 1; ld_gaps[3] = 3;
    do_load("stalls", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_idle_valid();
    for (int c = 0; c < 3; c++) begin
      coef_valid = 1'b1;
      coef_in = $urandom;
      abort = c[0];
      tick();
      checks++;
      if (busy !== 1'b0 || coef_ready !== 1'b0 || b !== model_vec()) begin
        errors++;
        $display("FAIL idle_valid: busy=%b ready=%b b=%h required 0 0 %h", busy, coef_ready, b, model_vec());
      end
    end
    coef_valid = 1'b0;
    abort = 1'b0;
    $display("idle valid dropped: b=%h", b);
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    coef_valid = 1'b1; coef_in = 32'd5; tick();
    coef_in = 32'd6; tick();
    coef_in = 32'd7; abort = 1'b1; tick();
    abort = 1'b0; coef_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || b !== model_vec()) begin
      errors++;
      $display("FAIL abort_state: busy=%b b=%h required 0 %h", busy, b, model_vec());
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != d0 || b !== model_vec()) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d b=%h required 0 %h", done_cnt - d0, b, model_vec());
    end
    $display("abort: b=%h", b);
    set_words(32'd8, 32'd9, 32'd10, 32'd11, 1'b0);
    do_load("after_abort", 1'b1, 1'b0, 1'b0);
    checks++;
    if (b !== 128'h0000000B_0000000A_00000009_00000008) begin
      errors++;
      $display("FAIL after_abort_const: b=%h required 0000000b0000000a0000000900000008", b);
    end
  endtask

  task automatic test_ignored_start();
    set_words($urandom, $urandom, $urandom, $urandom, 1'b0);
    do_load("ignored_start", 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_checksum();
`ifdef FIR_COEF_CHECKSUM_EN
    set_words(32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    ld_words[4] = 32'd10;
    do_load("csum_good", 1'b1, 1'b0, 1'b0);
    set_words(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
    ld_words[4] = 32'd0;
    do_load("csum_wrap", 1'b1, 1'b0, 1'b0);
    set_words(32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    ld_words[4] = 32'd11;
    do_load("csum_bad", 1'b0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    bit bad;
    for (int it = 0; it < 8; it++) begin
      bad = CSUM && ($urandom_range(0, 2) == 0);
      set_words($urandom, $urandom, $urandom, $urandom, bad);
      for (int k = 0; k < ld_n; k++) ld_gaps[k] = $urandom_range(0, 2);
      do_load($sformatf("rand%0d", it), !bad, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; tick(); start = 1'b0;
    coef_valid = 1'b1; coef_in = $urandom; tick();
    coef_in = $urandom; tick();
    coef_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (b !== '0 || coef_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: b=%h ready=%b busy=%b done=%b err=%b required all 0", b, coef_ready, busy, done, err);
    end
    for (int i = 0; i < NC; i++) model_b[i] = '0;
    $display("mid-load reset: b=%h busy=%b", b, busy);
    @(negedge clk);
    rst = 1'b0;
    tick();
    set_words(32'hDEAD_0001, 32'hBEEF_0002, 32'h1234_5678, 32'h0BAD_F00D, 1'b0);
    do_load("post_reset", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_idle_valid();
    test_abort();
    test_ignored_start();
    test_checksum();
    test_back_to_back();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Upstream coefficient loader for the tapped-delay FIR filter. It accepts coefficients one word at a time over a valid/ready stream, stages them in a shadow bank, and atomically updates the packed coefficient bus `b` that drives the filter. The filter therefore never sees a partially loaded coefficient set. It sits between the host/config interface and the FIR's `b` input, in the FIR's `clk` domain.

## Interface
- `DELAYS`, default 3: number of delay stages; the block loads DELAYS+1 coefficients.
- `N`, default 32: coefficient width in bits, matching the FIR's `N`.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a load sequence. Honoured only in IDLE.
- `abort`  in  1: cancels an in-progress load. The shadow bank is discarded and `b` is unchanged.
- `coef_in`  in  N: coefficient word.
- `coef_valid`  in  1: `coef_in` is valid this cycle.
- `coef_ready`  out  1: the loader accepts a word this cycle.
- `b`  out  (DELAYS+1)*N: packed coefficients. Coefficient i occupies `[(i+1)*N-1 : i*N]`.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse; `b` was updated on the same edge.
- `err`  out  1: one-cycle pulse on checksum mismatch. Constant 0 when the checksum feature is compiled out.

## Operation
- States are IDLE, LOAD, CHECK (only when `FIR_COEF_CHECKSUM_EN` is defined), and COMMIT.
- **Handshake.** A word transfers on a rising edge when `coef_valid & coef_ready`. `coef_ready` is a combinational decode of the state: it is 1 in LOAD and CHECK, 0 otherwise. It does not depend on `coef_valid`.
- **IDLE.** `start=1` and `abort=0` → LOAD, with index cleared to 0.
- **LOAD.** Each transfer writes `shadow[index] <= coef_in` and then `index++`.
  - The first word is coefficient 0 (`b[N-1:0]`); word i goes to slice i.
  - The transfer at `index==DELAYS` → CHECK if the checksum feature is enabled, otherwise → COMMIT.
  - The index counter is `$clog2(DELAYS+1)` bits wide, minimum 1, and never wraps because the state leaves LOAD at DELAYS.
- **CHECK.** Accepts exactly one word.
  - If the word equals the sum of the DELAYS+1 shadow words, truncated modulo 2^N → COMMIT.
  - Otherwise `err` pulses, the state returns to IDLE, and `b` is unchanged.
- **COMMIT.** Lasts one cycle. On the exiting edge: `b <= shadow`, `done <= 1`, state → IDLE.
- **abort.** Honoured in LOAD and CHECK, and has priority over a simultaneous transfer. The word is not written, the state returns to IDLE, and no `done` or `err` is produced.
  - `abort` in IDLE or COMMIT is ignored, so a commit already reached completes.
- **start outside IDLE** is ignored, including during COMMIT. `start` and `abort` asserted together in IDLE leave the state in IDLE.
- **coef_valid** outside LOAD/CHECK is ignored; the data is dropped and there is no backpressure memory.
- **Shadow bank** contents persist after `abort` or `err` but are never exposed. Each load fully rewrites them before any commit.

## Timing
- **Reset values:** state IDLE, index 0, shadow all 0, `b`=0, `coef_ready`=0, `busy`=0, `done`=0, `err`=0.
- **Reset mid-load** returns immediately to the reset values, including `b`=0. The FIR then runs with zero coefficients until the next load.
- `busy` rises in the cycle after the edge that samples `start`.
- **Latency without the checksum.** The last coefficient transfers at edge E. State is COMMIT during the following cycle. At edge E+1, `b` updates and `done` goes high for exactly one cycle.
- **Latency with the checksum.** The checksum word transfers at edge E, and the same E+1 timing applies. `err` is registered and appears one cycle after the checksum transfer, high for one cycle.
- **Minimum load time** is DELAYS+3 cycles from `start` to `done` (DELAYS+4 with the checksum), with `coef_valid` held high.
- `b` is constant between commits, so the FIR may sample it on any edge.

## Configuration
- The macro `FIR_COEF_CHECKSUM_EN` controls the checksum stage.
- **Defined:** the CHECK state exists, one trailing checksum word is required after the DELAYS+1 coefficients, and a mismatch blocks the commit and pulses `err`.
- **Undefined:** there is no CHECK state, the last coefficient goes directly to COMMIT, and `err` is tied to 0.

## Test plan
All scenarios use DELAYS=3 and N=32.
- **Reset:** assert `rst` asynchronously mid-cycle → `b`=0 and `coef_ready`=`busy`=`done`=`err`=0 immediately.
- **Basic load:** `start`, then words 1, 2, 3, 4 with `valid` held → `b`=0x00000004_00000003_00000002_00000001. `done` pulses once, DELAYS+3 cycles after `start`, and `busy` falls with it.
- **Stalls:** gaps in `coef_valid` between words → same `b`; `done` is delayed by exactly the number of gap cycles.
- **Abort:** load 5, 6, then `abort` together with `valid` for word 7 → `b` keeps its previous value, no `done`. A following load of 8, 9, 10, 11 → `b` = {11, 10, 9, 8}.
- **Checksum (`FIR_COEF_CHECKSUM_EN` defined):**
  - Words 1, 2, 3, 4, then checksum 10 → commit.
  - Words 0xFFFFFFFF, 1, 0, 0, then checksum 0 → commit (checksum wraps modulo 2^32).
  - Words 1, 2, 3, 4, then checksum 11 → `err` pulse, `b` unchanged, no `done`.
- **Ignored start:** a `start` pulse during LOAD and during COMMIT → no restart, no extra `done`, and the index sequence is intact.
